// File: rtl/projetof_pkg.sv
// Shared widths, scale constants and pipeline record types for the
// weigh-scale price calculator.
package projetof_pkg;

  localparam int CENTS_W = 9;
  localparam int GRAMS_W = 14;
  localparam int PROD_W  = 24;
  localparam int TOTAL_W = 14;
  localparam int OUT_W   = 16;

  localparam int GRAMS_PER_KG   = 1000;
  localparam int CENTS_PER_EURO = 100;
  localparam int ROUND_HALF     = 500;

  typedef struct packed {
    logic [CENTS_W-1:0] cents;
    logic [GRAMS_W-1:0] grams;
    logic [PROD_W-1:0]  prod;
  } stage1_t;

  typedef struct packed {
    logic [OUT_W-1:0] kg_int;
    logic [OUT_W-1:0] kg_frac;
    logic [OUT_W-1:0] price_int;
    logic [OUT_W-1:0] price_frac;
    logic [OUT_W-1:0] ppk_int;
    logic [OUT_W-1:0] ppk_frac;
  } result_t;

endpackage

// File: rtl/projetof_divmod.sv
// Combinational unsigned divide/modulo by a constant divisor; the quotient
// and remainder are resized to the widths the caller asks for.
module projetof_divmod #(
  parameter int IN_W    = 24,
  parameter int DIVISOR = 1000,
  parameter int Q_W     = IN_W,
  parameter int R_W     = IN_W
) (
  input  logic [IN_W-1:0] dividend_i,
  output logic [Q_W-1:0]  quotient_o,
  output logic [R_W-1:0]  remainder_o
);

  localparam logic [IN_W-1:0] DIV_C = IN_W'(DIVISOR);

  assign quotient_o  = Q_W'(dividend_i / DIV_C);
  assign remainder_o = R_W'(dividend_i % DIV_C);

endmodule

// File: rtl/projetof.sv
// Two-stage price calculator: stage 1 captures inputs and the cents*grams
// product, stage 2 registers the split weight, total price and unit price.
module projetof
  import projetof_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [CENTS_W-1:0] centimos,
  input  logic [GRAMS_W-1:0] pesoemgramas,
  output logic [OUT_W-1:0]   Peso_Final_unidades,
  output logic [OUT_W-1:0]   Peso_Final_decimal,
  output logic [OUT_W-1:0]   Preco_Parte_Inteira,
  output logic [OUT_W-1:0]   Preco_Parte_Decimal,
  output logic [OUT_W-1:0]   Preco_Por_Kg_Parte_Inteira,
  output logic [OUT_W-1:0]   Preco_Por_Kg_Parte_Decimal
);

  stage1_t s1_d, s1_q;
  result_t res_d, res_q;

  logic [PROD_W-1:0]  rounded_prod;
  logic [TOTAL_W-1:0] total_cents;
  logic [PROD_W-1:0]  unused_round_rem;
  logic [OUT_W-1:0]   kg_int, kg_frac, price_int, price_frac, ppk_int, ppk_frac;

  always_comb begin
    s1_d       = '0;
    s1_d.cents = centimos;
    s1_d.grams = pesoemgramas;
    s1_d.prod  = PROD_W'(centimos) * PROD_W'(pesoemgramas);
  end

  always_ff @(posedge clk) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_d;
  end

  // Adding half the divisor before truncating division rounds half up.
  assign rounded_prod = s1_q.prod + PROD_W'(ROUND_HALF);

  projetof_divmod #(
    .IN_W(GRAMS_W), .DIVISOR(GRAMS_PER_KG), .Q_W(OUT_W), .R_W(OUT_W)
  ) u_weight (
    .dividend_i (s1_q.grams),
    .quotient_o (kg_int),
    .remainder_o(kg_frac)
  );

  projetof_divmod #(
    .IN_W(PROD_W), .DIVISOR(GRAMS_PER_KG), .Q_W(TOTAL_W), .R_W(PROD_W)
  ) u_round (
    .dividend_i (rounded_prod),
    .quotient_o (total_cents),
    .remainder_o(unused_round_rem)
  );

  projetof_divmod #(
    .IN_W(TOTAL_W), .DIVISOR(CENTS_PER_EURO), .Q_W(OUT_W), .R_W(OUT_W)
  ) u_price (
    .dividend_i (total_cents),
    .quotient_o (price_int),
    .remainder_o(price_frac)
  );

  projetof_divmod #(
    .IN_W(CENTS_W), .DIVISOR(CENTS_PER_EURO), .Q_W(OUT_W), .R_W(OUT_W)
  ) u_ppk (
    .dividend_i (s1_q.cents),
    .quotient_o (ppk_int),
    .remainder_o(ppk_frac)
  );

  always_comb begin
    res_d            = '0;
    res_d.kg_int     = kg_int;
    res_d.kg_frac    = kg_frac;
    res_d.price_int  = price_int;
    res_d.price_frac = price_frac;
    res_d.ppk_int    = ppk_int;
    res_d.ppk_frac   = ppk_frac;
  end

  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign Peso_Final_unidades        = res_q.kg_int;
  assign Peso_Final_decimal         = res_q.kg_frac;
  assign Preco_Parte_Inteira        = res_q.price_int;
  assign Preco_Parte_Decimal        = res_q.price_frac;
  assign Preco_Por_Kg_Parte_Inteira = res_q.ppk_int;
  assign Preco_Por_Kg_Parte_Decimal = res_q.ppk_frac;

endmodule

// File: tb/tb_projetof.sv
// Directed-vector bench for projetof: reset, latency, rounding boundaries,
// back-to-back streaming and mid-flight reset.
module tb_projetof;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  centimos;
  logic [13:0] pesoemgramas;
  logic [15:0] pf_u, pf_d, pr_i, pr_d, pk_i, pk_d;

  int n_total = 0;
  int n_bad   = 0;

  localparam int NV = 9;
  int vc [NV];
  int vg [NV];
  int ex [NV][6];

  projetof dut (
    .clk                       (clk),
    .rst                       (rst),
    .centimos                  (centimos),
    .pesoemgramas              (pesoemgramas),
    .Peso_Final_unidades       (pf_u),
    .Peso_Final_decimal        (pf_d),
    .Preco_Parte_Inteira       (pr_i),
    .Preco_Parte_Decimal       (pr_d),
    .Preco_Por_Kg_Parte_Inteira(pk_i),
    .Preco_Por_Kg_Parte_Decimal(pk_d)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_vec(input string tag, input int k);
    check_val({tag, ".kg_u"},  int'(pf_u), ex[k][0]);
    check_val({tag, ".kg_d"},  int'(pf_d), ex[k][1]);
    check_val({tag, ".pr_i"},  int'(pr_i), ex[k][2]);
    check_val({tag, ".pr_d"},  int'(pr_d), ex[k][3]);
    check_val({tag, ".ppk_i"}, int'(pk_i), ex[k][4]);
    check_val({tag, ".ppk_d"}, int'(pk_d), ex[k][5]);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".kg_u"},  int'(pf_u), 0);
    check_val({tag, ".kg_d"},  int'(pf_d), 0);
    check_val({tag, ".pr_i"},  int'(pr_i), 0);
    check_val({tag, ".pr_d"},  int'(pr_d), 0);
    check_val({tag, ".ppk_i"}, int'(pk_i), 0);
    check_val({tag, ".ppk_d"}, int'(pk_d), 0);
  endtask

  task automatic drive(input int k);
    centimos     = 9'(vc[k]);
    pesoemgramas = 14'(vg[k]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // cents, grams -> kg_u kg_d pr_i pr_d ppk_i ppk_d
    vc[0] = 470; vg[0] = 1500;  ex[0] = '{1, 500, 7, 5, 4, 70};
    vc[1] = 511; vg[1] = 16383; ex[1] = '{16, 383, 83, 72, 5, 11};
    vc[2] = 100; vg[2] = 5;     ex[2] = '{0, 5, 0, 1, 1, 0};
    vc[3] = 100; vg[3] = 4;     ex[3] = '{0, 4, 0, 0, 1, 0};
    vc[4] = 199; vg[4] = 333;   ex[4] = '{0, 333, 0, 66, 1, 99};
    vc[5] = 0;   vg[5] = 999;   ex[5] = '{0, 999, 0, 0, 0, 0};
    vc[6] = 250; vg[6] = 0;     ex[6] = '{0, 0, 0, 0, 2, 50};
    vc[7] = 123; vg[7] = 2500;  ex[7] = '{2, 500, 3, 8, 1, 23};
    vc[8] = 149; vg[8] = 1004;  ex[8] = '{1, 4, 1, 50, 1, 49};

    rst = 1'b1;
    centimos = 9'd470;
    pesoemgramas = 14'd1500;
    tick();
    tick();
    check_zero("reset");

    // Isolated vector: nothing after the first edge, result after the second.
    rst = 1'b0;
    drive(0);
    tick();
    check_zero("lat1");
    tick();
    check_vec("lat2", 0);

    // Back-to-back stream: each result lands one edge after its sampling edge.
    drive(0);
    tick();
    for (int i = 1; i <= NV; i++) begin
      if (i < NV) drive(i);
      tick();
      check_vec($sformatf("v%0d", i - 1), i - 1);
    end

    // Mid-flight reset: in-flight samples discarded.
    drive(1);
    tick();
    drive(7);
    rst = 1'b1;
    tick();
    check_zero("rst_mid");
    rst = 1'b0;
    drive(8);
    tick();
    check_zero("rst_rel1");
    drive(2);
    tick();
    check_vec("rst_rel2", 8);
    tick();
    check_vec("rst_rel3", 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
